// File: rtl/block_interleaver.sv
// Block interleaver with two ping-pong banks of ROWS*COLS symbols.
// Each block is written row-major and read back column-major. A
// registered output stage presents each symbol on an AXI-Stream style
// handshake. A per-bank FREE/FULL flag decides which side may touch
// each bank.

module block_interleaver #(
    parameter int WIDTH = 1,
    parameter int ROWS  = 4,
    parameter int COLS  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast
);

    localparam int N  = ROWS * COLS;
    localparam int AW = $clog2(N);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    localparam logic [AW-1:0] W_LAST = AW'(N - 1);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

    localparam logic FREE = 1'b0;
    localparam logic FULL = 1'b1;

    // Symbol storage, one array per bank; deliberately not reset
    logic [WIDTH-1:0] mem0 [0:N-1];
    logic [WIDTH-1:0] mem1 [0:N-1];

    logic [1:0]       bank_full;
    logic             wr_bank;
    logic             rd_bank;
    logic [AW-1:0]    w_cnt;
    logic [RW-1:0]    r_cnt;
    logic [CW-1:0]    c_cnt;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             wr_en;
    logic             wr_done;
    logic             rd_en;
    logic             rd_last;
    logic             rd_done;

    // Ready comes straight from flops (flag and bank pointer), so a bank
    // freed on one edge only raises ready after that edge.
    assign s_axis_tready = (bank_full[wr_bank] == FREE);
    assign wr_en         = s_axis_tvalid && s_axis_tready;
    assign wr_done       = wr_en && (w_cnt == W_LAST);

    // A load happens whenever the read bank holds a complete block and
    // the output register is empty or being drained this cycle.
    assign rd_en   = (bank_full[rd_bank] == FULL) && (!m_axis_tvalid || m_axis_tready);
    assign rd_last = (r_cnt == R_LAST) && (c_cnt == C_LAST);
    assign rd_done = rd_en && rd_last;

    assign rd_addr = AW'(r_cnt) * AW'(COLS) + AW'(c_cnt);
    assign rd_data = rd_bank ? mem1[rd_addr] : mem0[rd_addr];

    // Store accepted symbols row-major into the current write bank
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_bank) begin
                mem1[w_cnt] <= s_axis_tdata;
            end else begin
                mem0[w_cnt] <= s_axis_tdata;
            end
        end
    end

    // Write address counter; wraps at N-1 and flips to the other bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_cnt   <= '0;
            wr_bank <= 1'b0;
        end else if (wr_en) begin
            if (w_cnt == W_LAST) begin
                w_cnt   <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                w_cnt <= w_cnt + 1'b1;
            end
        end
    end

    // Bank flags: the writer marks its bank FULL, the reader marks its bank
    // FREE. The two always target different banks, so both can apply at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_full <= '0;
        end else begin
            if (wr_done) begin
                bank_full[wr_bank] <= FULL;
            end
            if (rd_done) begin
                bank_full[rd_bank] <= FREE;
            end
        end
    end

    // Column-major read counters: row is the inner loop, column the outer loop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            c_cnt   <= '0;
            rd_bank <= 1'b0;
        end else if (rd_en) begin
            if (rd_last) begin
                r_cnt   <= '0;
                c_cnt   <= '0;
                rd_bank <= ~rd_bank;
            end else if (r_cnt == R_LAST) begin
                r_cnt <= '0;
                c_cnt <= c_cnt + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Output register: loads on a read, empties on a handshake with no
    // reload, and holds everything while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (rd_en) begin
            m_axis_tdata  <= rd_data;
            m_axis_tlast  <= rd_last;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule
